// File: rtl/victim_writeback_buffer.sv
// victim_writeback_buffer
// Age-ordered FIFO of dirty victim lines. Each line is written back to memory
// over the shared bus, one at a time. Queued lines are forwarded to MSHR
// lookups so that an in-flight writeback never exposes stale memory data.
// Optional feature macro: VICTIM_WB_COALESCE_EN. When it is defined, a dirty
// row that matches a queued non-head entry overwrites that entry in place.
module victim_writeback_buffer #(
   parameter int XLEN      = 32,
   parameter int LINE_BITS = 5,
   parameter int DEPTH     = 4,
   parameter int N_LOOKUP  = 4,
   localparam int TAG_W    = XLEN - LINE_BITS - 3
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               ld_ev_valid,
   input  logic                               ld_ev_dirty,
   input  logic [TAG_W-1:0]                   ld_ev_tag,
   input  logic [LINE_BITS-1:0]               ld_ev_idx,
   input  logic [63:0]                        ld_ev_data,
   input  logic                               st_ev_valid,
   input  logic                               st_ev_dirty,
   input  logic [TAG_W-1:0]                   st_ev_tag,
   input  logic [LINE_BITS-1:0]               st_ev_idx,
   input  logic [63:0]                        st_ev_data,
   output logic                               wb_almost_full,
   output logic                               wb_empty,
   output logic                               overflow_err,
   output logic [1:0]                         proc2mem_command,
   output logic [XLEN-1:0]                    proc2mem_addr,
   output logic [63:0]                        proc2mem_data,
   input  logic                               mem_grant,
   input  logic [3:0]                         mem2proc_response,
   input  logic [N_LOOKUP-1:0]                lk_valid,
   input  logic [N_LOOKUP-1:0][XLEN-1:0]      lk_addr,
   output logic [N_LOOKUP-1:0]                lk_hit,
   output logic [N_LOOKUP-1:0][63:0]          lk_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_STORE = 2'd2;
`ifdef VICTIM_WB_COALESCE_EN
   localparam bit COALESCE = 1'b1;
`else
   localparam bit COALESCE = 1'b0;
`endif

   typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_e;

   logic [TAG_W-1:0]     tag_q  [DEPTH];
   logic [TAG_W-1:0]     tag_d  [DEPTH];
   logic [LINE_BITS-1:0] idx_q  [DEPTH];
   logic [LINE_BITS-1:0] idx_d  [DEPTH];
   logic [63:0]          data_q [DEPTH];
   logic [63:0]          data_d [DEPTH];
   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 overflow_q, overflow_d;
   state_e               state_q, state_d;

   logic                 ld_push_s, st_push_s, accept_s;
   logic                 ld_merge_s, st_merge_s;
   logic [PTR_W-1:0]     ld_merge_slot_s, st_merge_slot_s;
   logic                 lk_lsb_unused_s;

   assign ld_push_s = ld_ev_valid & ld_ev_dirty;
   assign st_push_s = st_ev_valid & st_ev_dirty;
   assign accept_s  = (state_q == ST_ISSUE) & mem_grant & (mem2proc_response != 4'd0);

   // Find a queued non-head entry that each eviction row could coalesce into.
   always_comb begin
      ld_merge_s      = 1'b0;
      st_merge_s      = 1'b0;
      ld_merge_slot_s = '0;
      st_merge_slot_s = '0;
      for (int s = 0; s < DEPTH; s++) begin
         if (COALESCE && valid_q[s] && (PTR_W'(s) != head_q)) begin
            if ({tag_q[s], idx_q[s]} == {ld_ev_tag, ld_ev_idx}) begin
               ld_merge_s      = 1'b1;
               ld_merge_slot_s = PTR_W'(s);
            end else begin
               ld_merge_s      = ld_merge_s;
            end
            if ({tag_q[s], idx_q[s]} == {st_ev_tag, st_ev_idx}) begin
               st_merge_s      = 1'b1;
               st_merge_slot_s = PTR_W'(s);
            end else begin
               st_merge_s      = st_merge_s;
            end
         end else begin
            ld_merge_s = ld_merge_s;
         end
      end
   end

   // Queue update: pop the accepted head, then place the load row before the store row.
   always_comb begin
      logic [CNT_W-1:0] fill_v;
      logic             ld_new_v;
      logic [PTR_W-1:0] ld_slot_v;
      tag_d      = tag_q;
      idx_d      = idx_q;
      data_d     = data_q;
      valid_d    = valid_q;
      tail_d     = tail_q;
      overflow_d = overflow_q;
      fill_v     = count_q;
      ld_new_v   = 1'b0;
      ld_slot_v  = tail_q;
      if (accept_s) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end else begin
         head_d          = head_q;
      end
      if (ld_push_s && ld_merge_s) begin
         data_d[ld_merge_slot_s] = ld_ev_data;
      end else if (ld_push_s && (fill_v == CNT_W'(DEPTH))) begin
         overflow_d = 1'b1;
      end else if (ld_push_s) begin
         tag_d[tail_d]   = ld_ev_tag;
         idx_d[tail_d]   = ld_ev_idx;
         data_d[tail_d]  = ld_ev_data;
         valid_d[tail_d] = 1'b1;
         ld_new_v        = 1'b1;
         ld_slot_v       = tail_d;
         tail_d          = tail_d + PTR_W'(1);
         fill_v          = fill_v + CNT_W'(1);
      end else begin
         ld_new_v        = 1'b0;
      end
      if (st_push_s && st_merge_s) begin
         data_d[st_merge_slot_s] = st_ev_data;
      end else if (st_push_s && COALESCE && ld_new_v &&
                   ({st_ev_tag, st_ev_idx} == {ld_ev_tag, ld_ev_idx})) begin
         data_d[ld_slot_v] = st_ev_data;
      end else if (st_push_s && (fill_v == CNT_W'(DEPTH))) begin
         overflow_d = 1'b1;
      end else if (st_push_s) begin
         tag_d[tail_d]   = st_ev_tag;
         idx_d[tail_d]   = st_ev_idx;
         data_d[tail_d]  = st_ev_data;
         valid_d[tail_d] = 1'b1;
         tail_d          = tail_d + PTR_W'(1);
         fill_v          = fill_v + CNT_W'(1);
      end else begin
         fill_v          = fill_v;
      end
      count_d = fill_v - (accept_s ? CNT_W'(1) : CNT_W'(0));
   end

   // Next state: keep issuing while anything remains queued after this edge.
   always_comb begin
      case (state_q)
         ST_IDLE:  state_d = (count_d != CNT_W'(0)) ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: begin
            if (accept_s) begin
               state_d = (count_d != CNT_W'(0)) ? ST_ISSUE : ST_IDLE;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // State and queue storage; reset drops any line still waiting to be written back.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         valid_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int s = 0; s < DEPTH; s++) begin
            tag_q[s]  <= '0;
            idx_q[s]  <= '0;
            data_q[s] <= 64'd0;
         end
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         for (int s = 0; s < DEPTH; s++) begin
            tag_q[s]  <= tag_d[s];
            idx_q[s]  <= idx_d[s];
            data_q[s] <= data_d[s];
         end
      end
   end

   // Bus request and status flags; the address and data are zero unless a store is driven.
   always_comb begin
      case (state_q)
         ST_ISSUE: begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = {tag_q[head_q], idx_q[head_q], 3'b000};
            proc2mem_data    = data_q[head_q];
         end
         default: begin
            proc2mem_command = BUS_NONE;
            proc2mem_addr    = '0;
            proc2mem_data    = 64'd0;
         end
      endcase
      wb_empty       = (count_q == CNT_W'(0));
      wb_almost_full = (count_q >= CNT_W'(DEPTH - 1));
      overflow_err   = overflow_q;
   end

   // Forwarding: walk from oldest to youngest so that the youngest match is the one kept.
   always_comb begin
      logic [PTR_W-1:0] slot_v;
      lk_hit          = '0;
      lk_data         = '0;
      lk_lsb_unused_s = 1'b0;
      for (int i = 0; i < N_LOOKUP; i++) begin
         lk_lsb_unused_s = lk_lsb_unused_s ^ (^lk_addr[i][2:0]);
         for (int k = 0; k < DEPTH; k++) begin
            slot_v = head_q + PTR_W'(k);
            if (lk_valid[i] && valid_q[slot_v] &&
                (lk_addr[i][XLEN-1:3] == {tag_q[slot_v], idx_q[slot_v]})) begin
               lk_hit[i]  = 1'b1;
               lk_data[i] = data_q[slot_v];
            end else begin
               lk_hit[i]  = lk_hit[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Scoreboard bench for victim_writeback_buffer: expected memory writes are
// queued at stimulus time and compared by a monitor on every accepted request.
`timescale 1ns/1ps
module tb_victim_writeback_buffer;
   localparam int XLEN = 32, LINE_BITS = 5, DEPTH = 4, N_LOOKUP = 4;
   localparam int TAG_W = XLEN - LINE_BITS - 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic ld_ev_valid, ld_ev_dirty, st_ev_valid, st_ev_dirty;
   logic [TAG_W-1:0] ld_ev_tag, st_ev_tag;
   logic [LINE_BITS-1:0] ld_ev_idx, st_ev_idx;
   logic [63:0] ld_ev_data, st_ev_data;
   logic wb_almost_full, wb_empty, overflow_err;
   logic [1:0] proc2mem_command;
   logic [XLEN-1:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic mem_grant;
   logic [3:0] mem2proc_response;
   logic [N_LOOKUP-1:0] lk_valid, lk_hit;
   logic [N_LOOKUP-1:0][XLEN-1:0] lk_addr;
   logic [N_LOOKUP-1:0][63:0] lk_data;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] data;
   } wr_t;
   wr_t exp_q[$];

   always #5 clock = ~clock;
   assign mem2proc_response = mem_grant ? 4'd3 : 4'd0;

   victim_writeback_buffer dut (
      .clock(clock), .reset(reset),
      .ld_ev_valid(ld_ev_valid), .ld_ev_dirty(ld_ev_dirty), .ld_ev_tag(ld_ev_tag),
      .ld_ev_idx(ld_ev_idx), .ld_ev_data(ld_ev_data),
      .st_ev_valid(st_ev_valid), .st_ev_dirty(st_ev_dirty), .st_ev_tag(st_ev_tag),
      .st_ev_idx(st_ev_idx), .st_ev_data(st_ev_data),
      .wb_almost_full(wb_almost_full), .wb_empty(wb_empty), .overflow_err(overflow_err),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .mem_grant(mem_grant),
      .mem2proc_response(mem2proc_response),
      .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data)
   );

   function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] t, input logic [LINE_BITS-1:0] i);
      return {t, i, 3'b000};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ld(input logic v, input logic d, input logic [TAG_W-1:0] t,
                         input logic [LINE_BITS-1:0] i, input logic [63:0] dat);
      ld_ev_valid = v; ld_ev_dirty = d; ld_ev_tag = t; ld_ev_idx = i; ld_ev_data = dat;
   endtask

   task automatic set_st(input logic v, input logic d, input logic [TAG_W-1:0] t,
                         input logic [LINE_BITS-1:0] i, input logic [63:0] dat);
      st_ev_valid = v; st_ev_dirty = d; st_ev_tag = t; st_ev_idx = i; st_ev_data = dat;
   endtask

   task automatic clear_rows();
      set_ld(1'b0, 1'b0, '0, '0, 64'd0);
      set_st(1'b0, 1'b0, '0, '0, 64'd0);
   endtask

   task automatic expect_wr(input logic [TAG_W-1:0] t, input logic [LINE_BITS-1:0] i,
                            input logic [63:0] dat);
      wr_t w;
      w.addr = mk_addr(t, i);
      w.data = dat;
      exp_q.push_back(w);
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while (!wb_empty && n < budget) begin
         step();
         n++;
      end
      chk("drain_within_budget", {63'd0, wb_empty}, 64'd1);
   endtask

   // Monitor: every request that will be accepted at the next edge is popped and compared.
   always @(negedge clock) begin
      wr_t w;
      if (reset && proc2mem_command == 2'd2 && mem_grant) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=0x%0h/0x%0h required=none",
                     proc2mem_addr, proc2mem_data);
         end else begin
            w = exp_q.pop_front();
            chk("wb_addr", {32'd0, proc2mem_addr}, {32'd0, w.addr});
            chk("wb_data", proc2mem_data, w.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_rows();
      mem_grant = 1'b0;
      lk_valid  = '1;
      lk_addr   = '0;

      // reset state
      #12;
      chk("rst_empty", {63'd0, wb_empty}, 64'd1);
      chk("rst_almost_full", {63'd0, wb_almost_full}, 64'd0);
      chk("rst_cmd", {62'd0, proc2mem_command}, 64'd0);
      chk("rst_addr", {32'd0, proc2mem_addr}, 64'd0);
      chk("rst_data", proc2mem_data, 64'd0);
      chk("rst_ovf", {63'd0, overflow_err}, 64'd0);
      chk("rst_lk_hit", {60'd0, lk_hit}, 64'd0);
      chk("rst_lk_data2", lk_data[2], 64'd0);
      step();
      reset    = 1'b1;
      lk_valid = '0;

      // single push, with a clean store row that must be discarded
      set_ld(1'b1, 1'b1, 24'h0001A3, 5'd5, 64'hDEADBEEF_00112233);
      set_st(1'b1, 1'b0, 24'h000777, 5'd9, 64'h5555);
      expect_wr(24'h0001A3, 5'd5, 64'hDEADBEEF_00112233);
      step();
      clear_rows();
      #1;
      chk("single_not_empty", {63'd0, wb_empty}, 64'd0);
      chk("single_cmd", {62'd0, proc2mem_command}, 64'd2);
      chk("single_addr", {32'd0, proc2mem_addr}, 64'h0001A328);
      mem_grant = 1'b1;
      step();
      mem_grant = 1'b0;
      #1;
      chk("single_cmd_after", {62'd0, proc2mem_command}, 64'd0);
      chk("single_empty_after", {63'd0, wb_empty}, 64'd1);

      // dual push: load row is older and goes first, no bubble between writes
      set_ld(1'b1, 1'b1, 24'h000010, 5'd1, 64'hA1);
      set_st(1'b1, 1'b1, 24'h000010, 5'd2, 64'hA2);
      expect_wr(24'h000010, 5'd1, 64'hA1);
      expect_wr(24'h000010, 5'd2, 64'hA2);
      step();
      clear_rows();
      mem_grant = 1'b1;
      #1;
      chk("dual_first_addr", {32'd0, proc2mem_addr}, 64'h1008);
      step();
      chk("dual_no_bubble_cmd", {62'd0, proc2mem_command}, 64'd2);
      chk("dual_second_addr", {32'd0, proc2mem_addr}, 64'h1010);
      step();
      mem_grant = 1'b0;
      #1;
      chk("dual_empty", {63'd0, wb_empty}, 64'd1);

      // backpressure and overflow
      set_ld(1'b1, 1'b1, 24'h000020, 5'd0, 64'hE0);
      expect_wr(24'h000020, 5'd0, 64'hE0);
      step();
      clear_rows();
      #1;
      chk("af_count1", {63'd0, wb_almost_full}, 64'd0);
      set_ld(1'b1, 1'b1, 24'h000020, 5'd1, 64'hE1);
      set_st(1'b1, 1'b1, 24'h000020, 5'd2, 64'hE2);
      expect_wr(24'h000020, 5'd1, 64'hE1);
      expect_wr(24'h000020, 5'd2, 64'hE2);
      step();
      clear_rows();
      #1;
      chk("af_count3", {63'd0, wb_almost_full}, 64'd1);
      chk("ovf_before", {63'd0, overflow_err}, 64'd0);
      set_ld(1'b1, 1'b1, 24'h000020, 5'd3, 64'hE3);
      set_st(1'b1, 1'b1, 24'h000020, 5'd4, 64'hE4);
      expect_wr(24'h000020, 5'd3, 64'hE3);
      step();
      clear_rows();
      #1;
      chk("ovf_set", {63'd0, overflow_err}, 64'd1);
      chk("af_full", {63'd0, wb_almost_full}, 64'd1);

      // hold stable without grant, and forward queued data
      for (int c = 0; c < 10; c++) begin
         step();
         chk("hold_cmd", {62'd0, proc2mem_command}, 64'd2);
         chk("hold_addr", {32'd0, proc2mem_addr}, {32'd0, mk_addr(24'h000020, 5'd0)});
         chk("hold_data", proc2mem_data, 64'hE0);
      end
      lk_valid[2] = 1'b1;
      lk_addr[2]  = mk_addr(24'h000020, 5'd2);
      #1;
      chk("lk_hit_queued", {63'd0, lk_hit[2]}, 64'd1);
      chk("lk_data_queued", lk_data[2], 64'hE2);
      chk("lk_other_port", {63'd0, lk_hit[1]}, 64'd0);
      lk_addr[2] = mk_addr(24'h000020, 5'd0);
      mem_grant  = 1'b1;
      #1;
      chk("lk_same_cycle_hit", {63'd0, lk_hit[2]}, 64'd1);
      chk("lk_same_cycle_data", lk_data[2], 64'hE0);
      step();
      chk("lk_after_accept_hit", {63'd0, lk_hit[2]}, 64'd0);
      chk("lk_after_accept_data", lk_data[2], 64'd0);
      lk_valid = '0;
      wait_empty(20);
      mem_grant = 1'b0;
      #1;
      chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);

      // duplicate address behind a different head
      set_ld(1'b1, 1'b1, 24'h000055, 5'd7, 64'h99);
      expect_wr(24'h000055, 5'd7, 64'h99);
      step();
      set_ld(1'b1, 1'b1, 24'h00003C, 5'd3, 64'h1);
      step();
      set_ld(1'b1, 1'b1, 24'h00003C, 5'd3, 64'h2);
      step();
      clear_rows();
`ifdef VICTIM_WB_COALESCE_EN
      expect_wr(24'h00003C, 5'd3, 64'h2);
`else
      expect_wr(24'h00003C, 5'd3, 64'h1);
      expect_wr(24'h00003C, 5'd3, 64'h2);
`endif
      lk_valid[0] = 1'b1;
      lk_addr[0]  = mk_addr(24'h00003C, 5'd3);
      #1;
      chk("dup_lk_hit", {63'd0, lk_hit[0]}, 64'd1);
      chk("dup_lk_data", lk_data[0], 64'h2);
      mem_grant = 1'b1;
      wait_empty(20);
      mem_grant = 1'b0;
      lk_valid  = '0;
      chk("scoreboard_drained", {32'd0, exp_q.size()}, 64'd0);

      // asynchronous reset while a request is outstanding
      set_ld(1'b1, 1'b1, 24'h000066, 5'd4, 64'hAB);
      step();
      clear_rows();
      #1;
      chk("pre_reset_issue", {62'd0, proc2mem_command}, 64'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_cmd", {62'd0, proc2mem_command}, 64'd0);
      chk("async_rst_addr", {32'd0, proc2mem_addr}, 64'd0);
      chk("async_rst_empty", {63'd0, wb_empty}, 64'd1);
      chk("async_rst_ovf", {63'd0, overflow_err}, 64'd0);
      step();
      reset = 1'b1;
      step();
      chk("post_rst_cmd", {62'd0, proc2mem_command}, 64'd0);
      chk("post_rst_empty", {63'd0, wb_empty}, 64'd1);
      chk("final_queue_empty", {32'd0, exp_q.size()}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
